jtgng_rom_arb: RTL and testbench



---
 rtl/jtgng_rom_pkg.sv | 9 +
 rtl/jtgng_rom_slot.sv | 40 ++++
 rtl/jtgng_rom_arb.sv | 119 +++++++++++
 tb/tb_jtgng_rom_arb.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/jtgng_rom_pkg.sv
// jtgng_rom_pkg: shared widths, FSM encoding and default timing for the ROM arbiter
package jtgng_rom_pkg;
  localparam int ROM_AW = 22;
  localparam int ROM_DW = 32;
  localparam int ROM_DATA_LAT = 8;
  localparam int ROM_REFRESH_GAP = 64;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;
endpackage

// File: rtl/jtgng_rom_slot.sv
// jtgng_rom_slot: one-word cache slot per client with tag compare and load/clear
module jtgng_rom_slot
  import jtgng_rom_pkg::*;
#(
  parameter int AW = ROM_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic              i_cs,
  input  logic [AW-1:0]     i_addr,
  input  logic [AW-1:0]     i_tag,
  input  logic [ROM_DW-1:0] i_data,
  output logic              o_ok,
  output logic              o_miss,
  output logic [ROM_DW-1:0] o_dout
);
  logic              r_valid;
  logic [AW-1:0]     r_tag;
  logic [ROM_DW-1:0] r_dout;
  logic              w_hit;
  assign w_hit  = r_valid && (i_addr == r_tag);
  assign o_ok   = i_cs && w_hit;
  assign o_miss = i_cs && !w_hit;
  assign o_dout = r_dout;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_dout  <= '0;
    end else begin
      if (i_load) begin
        r_tag  <= i_tag;
        r_dout <= i_data;
      end
      r_valid <= !i_clr && (i_load || r_valid);
    end
  end
endmodule

// File: rtl/jtgng_rom_arb.sv
// jtgng_rom_arb: priority arbiter of cached ROM clients onto one toggle-request SDRAM read port,
// with idle-time repeat-address toggles so the controller can refresh.
module jtgng_rom_arb
  import jtgng_rom_pkg::*;
#(
  parameter int N           = 4,
  parameter int AW          = ROM_AW,
  parameter int DATA_LAT    = ROM_DATA_LAT,
  parameter int REFRESH_GAP = ROM_REFRESH_GAP
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                loop_rst,
  input  logic                downloading,
  input  logic [N-1:0]        cs,
  input  logic [N*AW-1:0]     addr,
  output logic [N-1:0]        data_ok,
  output logic [N*ROM_DW-1:0] dout,
  output logic                read_req,
  output logic [AW-1:0]       sdram_addr,
  input  logic [ROM_DW-1:0]   data_read
);
  localparam int SW = N > 1 ? $clog2(N) : 1;
  localparam int WW = DATA_LAT > 1 ? $clog2(DATA_LAT) : 1;
  localparam int IW = REFRESH_GAP > 1 ? $clog2(REFRESH_GAP) : 1;
  localparam logic [WW-1:0] WAIT_MAX = WW'(DATA_LAT - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(REFRESH_GAP - 1);
  logic [0:0]    r_state;
  logic [WW-1:0] r_wait;
  logic [IW-1:0] r_idle;
  logic [SW-1:0] r_sel;
  logic [AW-1:0] r_req_addr;
  logic [AW-1:0] r_sdram_addr;
  logic          r_read_req;
  logic          r_refresh;
  logic          r_abort;
  logic [N-1:0]  w_miss;
  logic [SW-1:0] w_sel;
  logic [AW-1:0] w_addr;
  logic          w_any;
  logic          w_cap;
  logic          w_go;
  assign read_req   = r_read_req;
  assign sdram_addr = r_sdram_addr;
  assign w_go       = !loop_rst && !downloading;
  assign w_cap      = (r_state == ST_WAIT) && (r_wait == '0) && !r_refresh && !r_abort && !downloading;
  // Descending scan leaves the lowest-index missing client selected
  always_comb begin
    w_sel  = '0;
    w_addr = '0;
    w_any  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_miss[i]) begin
        w_sel  = SW'(i);
        w_addr = addr[i*AW +: AW];
        w_any  = 1'b1;
      end
    end
  end
  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_slot
      jtgng_rom_slot #(.AW(AW)) u_slot (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (downloading),
        .i_load (w_cap && (r_sel == SW'(g))),
        .i_cs   (cs[g]),
        .i_addr (addr[g*AW +: AW]),
        .i_tag  (r_req_addr),
        .i_data (data_read),
        .o_ok   (data_ok[g]),
        .o_miss (w_miss[g]),
        .o_dout (dout[g*ROM_DW +: ROM_DW])
      );
    end
  endgenerate
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_wait       <= '0;
      r_idle       <= '0;
      r_sel        <= '0;
      r_req_addr   <= '0;
      r_sdram_addr <= '0;
      r_read_req   <= 1'b0;
      r_refresh    <= 1'b0;
      r_abort      <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (!w_go) begin
        r_idle <= '0;
      end else if (w_any) begin
        r_sel        <= w_sel;
        r_req_addr   <= w_addr;
        r_sdram_addr <= w_addr;
        r_read_req   <= ~r_read_req;
        r_refresh    <= 1'b0;
        r_abort      <= 1'b0;
        r_wait       <= WAIT_MAX;
        r_idle       <= '0;
        r_state      <= ST_WAIT;
      end else if (r_idle == IDLE_MAX) begin
        // Same address toggled again: the controller turns it into a refresh
        r_read_req <= ~r_read_req;
        r_refresh  <= 1'b1;
        r_abort    <= 1'b0;
        r_wait     <= WAIT_MAX;
        r_idle     <= '0;
        r_state    <= ST_WAIT;
      end else begin
        r_idle <= r_idle + 1'b1;
      end
    end else begin
      r_wait  <= r_wait == '0 ? '0 : r_wait - 1'b1;
      r_abort <= r_abort || downloading;
      r_state <= r_wait == '0 ? ST_IDLE : ST_WAIT;
    end
  end
endmodule

// File: tb/tb_jtgng_rom_arb.sv
// tb_jtgng_rom_arb: directed checks of miss latency, hits, priority, refresh, download and abort
module tb_jtgng_rom_arb;
  localparam int N = 4;
  localparam int AW = 22;
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            loop_rst = 1'b0;
  logic            downloading = 1'b0;
  logic [N-1:0]    cs = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N-1:0]    data_ok;
  logic [N*32-1:0] dout;
  logic            read_req;
  logic [AW-1:0]   sdram_addr;
  logic [31:0]     data_read = '0;
  int checks = 0;
  int failures = 0;
  int toggles = 0;
  logic rr_last = 1'b0;

  jtgng_rom_arb dut (
    .clk(clk), .rst(rst), .loop_rst(loop_rst), .downloading(downloading),
    .cs(cs), .addr(addr), .data_ok(data_ok), .dout(dout),
    .read_req(read_req), .sdram_addr(sdram_addr), .data_read(data_read)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (read_req !== rr_last) toggles++;
    rr_last = read_req;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    step(3);
    chk("rst_read_req", 64'(read_req), 64'd0);
    chk("rst_sdram_addr", 64'(sdram_addr), 64'd0);
    chk("rst_data_ok", 64'(data_ok), 64'd0);
    chk("rst_dout", 64'(dout[63:0]), 64'd0);
    rst = 1'b0;
    // single miss on client 2
    cs = 4'b0100;
    addr[2*AW +: AW] = 22'h01234;
    data_read = 32'hCAFEBABE;
    #1;
    chk("miss_no_ok", 64'(data_ok), 64'd0);
    step(1);
    chk("miss_toggle", 64'(toggles), 64'd1);
    chk("miss_addr", 64'(sdram_addr), 64'h01234);
    step(7);
    chk("miss_early", 64'(data_ok[2]), 64'd0);
    step(1);
    chk("miss_ok", 64'(data_ok[2]), 64'd1);
    chk("miss_dout", 64'(dout[2*32 +: 32]), 64'hCAFEBABE);
    // hits: no traffic, same-cycle data_ok
    data_read = 32'h55555555;
    step(3);
    chk("hit_ok", 64'(data_ok), 64'b0100);
    cs = 4'b0000;
    #1;
    chk("hit_cs_low", 64'(data_ok), 64'd0);
    cs = 4'b0100;
    #1;
    chk("hit_same_cycle", 64'(data_ok), 64'b0100);
    chk("hit_no_toggle", 64'(toggles), 64'd1);
    chk("hit_dout", 64'(dout[2*32 +: 32]), 64'hCAFEBABE);
    // priority: clients 0 and 3 miss together
    cs = 4'b1101;
    addr[0 +: AW] = 22'h00AAA;
    addr[3*AW +: AW] = 22'h3ABCD;
    data_read = 32'h11111111;
    step(1);
    chk("pri_first_toggle", 64'(toggles), 64'd2);
    chk("pri_first_addr", 64'(sdram_addr), 64'h00AAA);
    step(8);
    chk("pri_ok0", 64'(data_ok), 64'b0101);
    chk("pri_dout0", 64'(dout[0 +: 32]), 64'h11111111);
    chk("pri_second_pending", 64'(toggles), 64'd2);
    data_read = 32'h33333333;
    step(1);
    chk("pri_second_toggle", 64'(toggles), 64'd3);
    chk("pri_second_addr", 64'(sdram_addr), 64'h3ABCD);
    step(8);
    chk("pri_ok_all", 64'(data_ok), 64'b1101);
    chk("pri_dout3", 64'(dout[3*32 +: 32]), 64'h33333333);
    // refresh after 64 idle cycles
    cs = 4'b0000;
    data_read = 32'hDEADDEAD;
    step(63);
    chk("ref_not_yet", 64'(toggles), 64'd3);
    step(1);
    chk("ref_toggle", 64'(toggles), 64'd4);
    chk("ref_addr_same", 64'(sdram_addr), 64'h3ABCD);
    step(8);
    cs = 4'b1101;
    #1;
    chk("ref_cache_intact", 64'(data_ok), 64'b1101);
    chk("ref_dout0", 64'(dout[0 +: 32]), 64'h11111111);
    chk("ref_dout3", 64'(dout[3*32 +: 32]), 64'h33333333);
    step(1);
    chk("ref_no_extra", 64'(toggles), 64'd4);
    // download invalidates everything and blocks requests
    downloading = 1'b1;
    step(1);
    chk("dl_cleared", 64'(data_ok), 64'd0);
    step(9);
    chk("dl_still_clear", 64'(data_ok), 64'd0);
    chk("dl_no_toggle", 64'(toggles), 64'd4);
    downloading = 1'b0;
    data_read = 32'h77777777;
    #1;
    chk("dl_after_ok", 64'(data_ok), 64'd0);
    step(1);
    chk("dl_refetch_toggle", 64'(toggles), 64'd5);
    chk("dl_refetch_addr", 64'(sdram_addr), 64'h00AAA);
    // abort: download pulse 3 cycles into WAIT
    step(2);
    downloading = 1'b1;
    step(1);
    downloading = 1'b0;
    step(5);
    chk("abort_no_ok", 64'(data_ok), 64'd0);
    chk("abort_no_new_toggle", 64'(toggles), 64'd5);
    data_read = 32'h99999999;
    step(1);
    chk("abort_retry_toggle", 64'(toggles), 64'd6);
    chk("abort_retry_addr", 64'(sdram_addr), 64'h00AAA);
    step(8);
    chk("abort_final_ok0", 64'(data_ok[0]), 64'd1);
    chk("abort_final_dout0", 64'(dout[0 +: 32]), 64'h99999999);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
